// File: rtl/muldiv_unit.sv
// RV32/64 M-extension multiply/divide unit: iterative shift-add multiply, restoring divide,
// with fast paths for divide-by-zero, signed overflow and an optional single-cycle multiplier.
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] OPERAND_A,
  input  logic [XLEN-1:0] OPERAND_B,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t            state;
  logic [2:0]        funct_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   opnd_reg;
  logic [CW-1:0]     count_reg;
  logic              neg_reg;
  logic              rem_neg_reg;

  // Operand conditioning for the request presented this cycle
  logic              a_signed, b_signed;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              is_div, div_zero, div_ovf;
  logic [2*XLEN-1:0] fast_prod;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (FUNCT3)
      3'b001:         begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:         a_signed = 1'b1;
      3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      default:        ;
    endcase
  end

  assign sign_a    = a_signed & OPERAND_A[XLEN-1];
  assign sign_b    = b_signed & OPERAND_B[XLEN-1];
  assign mag_a     = sign_a ? -OPERAND_A : OPERAND_A;
  assign mag_b     = sign_b ? -OPERAND_B : OPERAND_B;
  assign is_div    = FUNCT3[2];
  assign div_zero  = is_div && (OPERAND_B == '0);
  assign div_ovf   = is_div && !FUNCT3[0] && (OPERAND_A == MIN_VAL) && (OPERAND_B == '1);
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};

  // One iteration: acc holds {partial product, remaining multiplier} for multiply
  // and {partial remainder, dividend/quotient bits} for divide.
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd_reg};
    div_rem   = div_ge ? XLEN'(div_shift - {1'b0, opnd_reg}) : div_shift[XLEN-1:0];
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    if (funct_reg[2])
      acc_step = {div_rem, acc_reg[XLEN-2:0], div_ge};
    else
      acc_step = {mul_sum, acc_reg[XLEN-1:1]};
  end

  // Sign fix-up and result selection applied in FINISH
  logic [2*XLEN-1:0] prod_final;
  logic [XLEN-1:0]   quo_final, rem_final, result_final;

  always_comb begin
    prod_final = neg_reg ? -acc_reg : acc_reg;
    quo_final  = neg_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    rem_final  = rem_neg_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
    case (funct_reg)
      3'b000:                 result_final = prod_final[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_final = prod_final[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result_final = quo_final;
      default:                result_final = rem_final;
    endcase
  end

  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      funct_reg   <= '0;
      acc_reg     <= '0;
      opnd_reg    <= '0;
      count_reg   <= '0;
      neg_reg     <= 1'b0;
      rem_neg_reg <= 1'b0;
      DONE        <= 1'b0;
      RESULT      <= '0;
    end else begin
      DONE <= 1'b0;
      if (FLUSH) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (START) begin
              funct_reg <= FUNCT3;
              count_reg <= '0;
              if (div_zero) begin
                // Quotient all-ones, remainder is the raw dividend; no sign fix-up
                acc_reg     <= {OPERAND_A, {XLEN{1'b1}}};
                neg_reg     <= 1'b0;
                rem_neg_reg <= 1'b0;
                state       <= FINISH;
              end else if (div_ovf) begin
                acc_reg     <= {{XLEN{1'b0}}, MIN_VAL};
                neg_reg     <= 1'b0;
                rem_neg_reg <= 1'b0;
                state       <= FINISH;
              end else if (is_div) begin
                acc_reg     <= {{XLEN{1'b0}}, mag_a};
                opnd_reg    <= mag_b;
                neg_reg     <= sign_a ^ sign_b;
                rem_neg_reg <= sign_a;
                state       <= CALC;
              end else if (FAST_MUL != 0) begin
                acc_reg     <= fast_prod;
                neg_reg     <= sign_a ^ sign_b;
                rem_neg_reg <= 1'b0;
                state       <= FINISH;
              end else begin
                acc_reg     <= {{XLEN{1'b0}}, mag_b};
                opnd_reg    <= mag_a;
                neg_reg     <= sign_a ^ sign_b;
                rem_neg_reg <= 1'b0;
                state       <= CALC;
              end
            end
          end
          CALC: begin
            acc_reg   <= acc_step;
            count_reg <= count_reg + CW'(1);
            if (count_reg == CW'(XLEN - 1))
              state <= FINISH;
          end
          FINISH: begin
            RESULT <= result_final;
            DONE   <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: 32-bit iterative, 32-bit fast-multiply and 8-bit instances.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic        start0, start1, start2;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy0, done0, busy1, done1, busy2, done2;
  logic [31:0] res0, res1;
  logic [7:0]  res2;

  int checks   = 0;
  int failures = 0;
  int sel      = 0;

  logic        sel_busy, sel_done;
  logic [31:0] sel_res;

  always_comb begin
    sel_busy = busy0;
    sel_done = done0;
    sel_res  = res0;
    if (sel == 1) begin
      sel_busy = busy1; sel_done = done1; sel_res = res1;
    end else if (sel == 2) begin
      sel_busy = busy2; sel_done = done2; sel_res = {24'h0, res2};
    end
  end

  muldiv_unit #(.XLEN(32), .FAST_MUL(0)) u_dut (
    .CLK(clk), .RESET(rst), .START(start0), .FUNCT3(funct3),
    .OPERAND_A(op_a), .OPERAND_B(op_b), .FLUSH(flush),
    .BUSY(busy0), .DONE(done0), .RESULT(res0));

  muldiv_unit #(.XLEN(32), .FAST_MUL(1)) u_fast (
    .CLK(clk), .RESET(rst), .START(start1), .FUNCT3(funct3),
    .OPERAND_A(op_a), .OPERAND_B(op_b), .FLUSH(flush),
    .BUSY(busy1), .DONE(done1), .RESULT(res1));

  muldiv_unit #(.XLEN(8), .FAST_MUL(0)) u_small (
    .CLK(clk), .RESET(rst), .START(start2), .FUNCT3(funct3),
    .OPERAND_A(op_a[7:0]), .OPERAND_B(op_b[7:0]), .FLUSH(flush),
    .BUSY(busy2), .DONE(done2), .RESULT(res2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Edges counted inclusive of the accepting edge up to the edge that raises DONE.
  task automatic run_op(input int which, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_edges, input int exp_busy,
                        input logic [31:0] exp_res, input string tag);
    int edges;
    int busy_cnt;
    sel = which;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b;
    if (which == 0) start0 = 1'b1;
    else if (which == 1) start1 = 1'b1;
    else start2 = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    op_a = ~a; op_b = ~b; funct3 = ~f;
    busy_cnt = 0;
    while (!sel_done && edges < 200) begin
      if (sel_busy) busy_cnt++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, edges, exp_edges);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    chk({tag, "_result"}, sel_res, exp_res);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'h0, sel_done}, 32'h0);
    $display("op %s funct3=%0d a=0x%08h b=0x%08h result=0x%08h edges=%0d", tag, f, a, b, sel_res, edges);
  endtask

  initial begin
    int edges;
    int done_cnt;

    rst = 1'b1; flush = 1'b0;
    start0 = 1'b1; start1 = 1'b1; start2 = 1'b1;
    funct3 = 3'b000; op_a = 32'd5; op_b = 32'd5;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, busy0}, 32'h0);
    chk("rst_done", {31'h0, done0}, 32'h0);
    chk("rst_result", res0, 32'h0);
    chk("rst_busy_fast", {31'h0, busy1}, 32'h0);
    chk("rst_busy_small", {31'h0, busy2}, 32'h0);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {31'h0, busy0}, 32'h0);

    run_op(0, 3'b000, 32'd7, 32'hFFFFFFFD, 34, 33, 32'hFFFFFFEB, "mul");
    run_op(0, 3'b001, 32'h80000000, 32'hFFFFFFFF, 34, 33, 32'h00000000, "mulh");
    run_op(0, 3'b010, 32'h80000000, 32'hFFFFFFFF, 34, 33, 32'h80000000, "mulhsu");
    run_op(0, 3'b011, 32'h80000000, 32'hFFFFFFFF, 34, 33, 32'h7FFFFFFF, "mulhu");
    run_op(0, 3'b100, 32'hFFFFFFF9, 32'd2, 34, 33, 32'hFFFFFFFD, "div");
    run_op(0, 3'b110, 32'hFFFFFFF9, 32'd2, 34, 33, 32'hFFFFFFFF, "rem");
    run_op(0, 3'b101, 32'hFFFFFFFF, 32'h10, 34, 33, 32'h0FFFFFFF, "divu");
    run_op(0, 3'b101, 32'd5, 32'd0, 2, 1, 32'hFFFFFFFF, "divu_by_zero");
    run_op(0, 3'b110, 32'd5, 32'd0, 2, 1, 32'h00000005, "rem_by_zero");

    // Flush during CALC cycle 10 of a divide
    sel = 0;
    @(negedge clk);
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd3; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_busy_before", {31'h0, busy0}, 32'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_after", {31'h0, busy0}, 32'h0);
    chk("flush_result_held", res0, 32'h5);
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done0) done_cnt++;
    end
    chk("flush_no_done", done_cnt, 0);
    chk("flush_result_later", res0, 32'h5);
    $display("op flush_in_calc busy=%0d result=0x%08h done_count=%0d", busy0, res0, done_cnt);

    // Reset pulsed in the middle of a divide
    @(negedge clk);
    funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd7; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'h0, busy0}, 32'h0);
    chk("midrst_done", {31'h0, done0}, 32'h0);
    chk("midrst_result", res0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done0) done_cnt++;
    end
    chk("midrst_no_done", done_cnt, 0);
    $display("op reset_mid_divide busy=%0d result=0x%08h done_count=%0d", busy0, res0, done_cnt);

    run_op(0, 3'b101, 32'hFFFFFFFF, 32'h10, 34, 33, 32'h0FFFFFFF, "divu_after_rst");
    run_op(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 2, 1, 32'h80000000, "div_ovf");
    run_op(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 2, 1, 32'h00000000, "rem_ovf");

    // START held high across DONE: operands changed while busy must not restart
    sel = 0;
    @(negedge clk);
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; start0 = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    op_a = 32'd200; op_b = 32'd9;
    while (!done0 && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("b2b_first_latency", edges, 34);
    chk("b2b_first_result", res0, 32'd14);
    $display("op b2b_first result=0x%08h edges=%0d", res0, edges);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start0 = 1'b0;
    chk("b2b_second_busy", {31'h0, busy0}, 32'h1);
    chk("b2b_second_done_low", {31'h0, done0}, 32'h0);
    while (!done0 && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("b2b_second_latency", edges, 34);
    chk("b2b_second_result", res0, 32'd22);
    $display("op b2b_second result=0x%08h edges=%0d", res0, edges);

    run_op(1, 3'b000, 32'd3, 32'd4, 2, 1, 32'd12, "fast_mul");
    run_op(1, 3'b010, 32'h80000000, 32'hFFFFFFFF, 2, 1, 32'h80000000, "fast_mulhsu");
    run_op(2, 3'b101, 32'd200, 32'd7, 10, 9, 32'd28, "x8_divu");
    run_op(2, 3'b111, 32'd200, 32'd7, 10, 9, 32'd4, "x8_remu");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
